// File: rtl/act_pkg.sv
// Shared definitions for the activation requantizer: int8 activation range
// and the saturating narrow-to-activation helpers.
package act_pkg;

   localparam int OUT_W      = 8;
   localparam int ACT_QMIN   = -128;
   localparam int ACT_QMAX   = 127;
   // Width of the "wide" value handed to the saturation helpers; wide enough
   // for any rounded product of the default accumulator/scale widths.
   localparam int ACT_WIDE_W = 48;

   localparam logic signed [ACT_WIDE_W-1:0] ACT_WIDE_MAX = ACT_WIDE_W'(ACT_QMAX);
   localparam logic signed [ACT_WIDE_W-1:0] ACT_WIDE_MIN = ACT_WIDE_W'(ACT_QMIN);

   // Clamp a wide signed value onto the int8 activation range.
   function automatic logic signed [OUT_W-1:0] sat_to_act(input logic signed [ACT_WIDE_W-1:0] v);
      if (v > ACT_WIDE_MAX) begin
         return OUT_W'(ACT_QMAX);
      end
      if (v < ACT_WIDE_MIN) begin
         return OUT_W'(ACT_QMIN);
      end
      return v[OUT_W-1:0];
   endfunction

   // True when sat_to_act would have to clamp (either rail).
   function automatic logic act_is_sat(input logic signed [ACT_WIDE_W-1:0] v);
      return (v > ACT_WIDE_MAX) || (v < ACT_WIDE_MIN);
   endfunction

endpackage

// File: rtl/act_sync_fifo.sv
// Small synchronous FIFO with a registered head output. When the FIFO is
// empty the head register keeps the last value that was presented.
module act_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [AW-1:0]    w_rd_next;
   logic [WIDTH-1:0] w_head_next;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head      = r_head;
   assign w_push_ok = push & (~full | pop);
   assign w_pop_ok  = pop & ~empty;
   assign w_rd_next = r_rd_ptr + 1'b1;

   // Storage array; no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Next head: the entry behind the popped one, or fresh push data when the
   // FIFO is (or becomes) empty; otherwise hold.
   always_comb begin
      w_head_next = r_head;
      if (w_pop_ok) begin
         if (r_count > CW'(1)) begin
            w_head_next = r_mem[w_rd_next];
         end else if (w_push_ok) begin
            w_head_next = push_data;
         end
      end else if (empty && w_push_ok) begin
         w_head_next = push_data;
      end
   end

   // Pointers, occupancy and head register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         r_head <= w_head_next;
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/act_requant_stream.sv
// Requantizes signed accumulator values to int8 tanh inputs:
// x = sat((acc * scale + round) >>> shift), two arithmetic stages then an
// output FIFO. Input is credit throttled so the pipeline never stalls.
// Optional feature macro REQUANT_SAT_CNT_EN adds the sat_count output.
module act_requant_stream
   import act_pkg::*;
#(
   parameter int ACC_W      = 24,
   parameter int SCALE_W    = 16,
   parameter int SHIFT_W    = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ACC_W-1:0]   in_data,
   input  logic               cfg_load,
   input  logic [SCALE_W-1:0] cfg_scale,
   input  logic [SHIFT_W-1:0] cfg_shift,
   output logic               cfg_err,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   x_out
`ifdef REQUANT_SAT_CNT_EN
   ,
   output logic [15:0]        sat_count
`endif
);

   localparam int PROD_W = ACC_W + SCALE_W + 1;
   localparam int SUM_W  = PROD_W + 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [SCALE_W-1:0]       r_scale;
   logic [SHIFT_W-1:0]       r_shift;
   logic                     r_cfg_err;
   logic                     r_s1_valid;
   logic signed [PROD_W-1:0] r_s1_prod;
   logic                     r_s2_valid;
   logic [OUT_W-1:0]         r_s2_data;

   logic                         w_in_fire;
   logic                         w_cfg_accept;
   logic                         w_pop;
   logic                         w_empty;
   logic                         w_full;
   logic [CNT_W-1:0]             w_count;
   logic [CNT_W:0]               w_credit_sum;
   logic signed [PROD_W-1:0]     w_in_ext;
   logic signed [PROD_W-1:0]     w_scale_ext;
   logic signed [PROD_W-1:0]     w_prod;
   logic signed [SUM_W-1:0]      w_prod_ext;
   logic signed [SUM_W-1:0]      w_half;
   logic signed [SUM_W-1:0]      w_sum;
   logic signed [SUM_W-1:0]      w_shifted;
   logic signed [ACT_WIDE_W-1:0] w_wide;
   logic [OUT_W-1:0]             w_sat_val;

   assign w_in_fire    = in_valid & in_ready;
   assign busy         = r_s1_valid | r_s2_valid | (w_count != '0);
   // A config change is only safe with nothing in flight and nothing entering.
   assign w_cfg_accept = cfg_load & ~busy & ~w_in_fire;
   assign cfg_err      = r_cfg_err;

   // Credits: every value in S1/S2 already owns a FIFO slot, so a push never
   // finds the FIFO full. Registered state only; out_ready does not feed in.
   assign w_credit_sum = {1'b0, w_count}
                       + {{CNT_W{1'b0}}, r_s1_valid}
                       + {{CNT_W{1'b0}}, r_s2_valid};
   assign in_ready     = ~w_full & (w_credit_sum < (CNT_W+1)'(FIFO_DEPTH));

   // S1 product: scale is treated as unsigned, so it is zero extended.
   assign w_in_ext    = {{(PROD_W-ACC_W){in_data[ACC_W-1]}}, in_data};
   assign w_scale_ext = {{(PROD_W-SCALE_W){1'b0}}, r_scale};
   assign w_prod      = w_in_ext * w_scale_ext;

   // S2 rounding: add half an LSB of the result, then arithmetic shift
   // (round half toward +inf). One extra bit keeps the add from overflowing.
   assign w_prod_ext = {r_s1_prod[PROD_W-1], r_s1_prod};
   assign w_half     = (r_shift == '0) ? '0 : (SUM_W'(1) << (r_shift - SHIFT_W'(1)));
   assign w_sum      = w_prod_ext + w_half;
   assign w_shifted  = w_sum >>> r_shift;
   assign w_wide     = {{(ACT_WIDE_W-SUM_W){w_shifted[SUM_W-1]}}, w_shifted};
   assign w_sat_val  = sat_to_act(w_wide);

   // Runtime scale/shift and the rejected-load pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scale   <= SCALE_W'(1);
         r_shift   <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_load & ~w_cfg_accept;
         if (w_cfg_accept) begin
            r_scale <= cfg_scale;
            r_shift <= cfg_shift;
         end
      end
   end

   // Two arithmetic stages; valids advance every cycle, data only when valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_prod  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
      end else begin
         r_s1_valid <= w_in_fire;
         r_s2_valid <= r_s1_valid;
         if (w_in_fire) begin
            r_s1_prod <= w_prod;
         end
         if (r_s1_valid) begin
            r_s2_data <= w_sat_val;
         end
      end
   end

   assign out_valid = ~w_empty;
   assign w_pop     = out_valid & out_ready;

   act_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OUT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (r_s2_valid),
      .push_data (r_s2_data),
      .pop       (w_pop),
      .head      (x_out),
      .count     (w_count),
      .full      (w_full),
      .empty     (w_empty)
   );

`ifdef REQUANT_SAT_CNT_EN
   logic        w_clamped;
   logic [15:0] r_sat_cnt;

   assign w_clamped = act_is_sat(w_wide);
   assign sat_count = r_sat_cnt;

   // Count S2 results that hit a rail; sticks at all-ones, cleared on new config.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sat_cnt <= '0;
      end else if (w_cfg_accept) begin
         r_sat_cnt <= '0;
      end else if (r_s1_valid && w_clamped && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_act_requant_stream.sv
// Self-checking bench for act_requant_stream. A queue-based reference model
// tracks every accepted value (with its accept cycle) and predicts handshakes,
// busy, cfg_err and x_out each cycle. Honours REQUANT_SAT_CNT_EN.
module tb_act_requant_stream;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_data = '0;
   logic        cfg_load = 1'b0;
   logic [15:0] cfg_scale = '0;
   logic [4:0]  cfg_shift = '0;
   logic        cfg_err;
   logic        busy;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  x_out;
`ifdef REQUANT_SAT_CNT_EN
   logic [15:0] sat_count;
`endif

   act_requant_stream dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .cfg_load  (cfg_load),
      .cfg_scale (cfg_scale),
      .cfg_shift (cfg_shift),
      .cfg_err   (cfg_err),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out)
`ifdef REQUANT_SAT_CNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int v;
      int t;
   } item_t;

   item_t exp_q[$];
   int    got_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   int    n_acc = 0;
   int    m_scale = 1;
   int    m_shift = 0;
   int    m_sat = 0;
   int    last_pop = 0;
   bit    exp_cfg_err = 1'b0;

   task automatic chk(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Reference arithmetic: floor((x*scale + 2^(shift-1)) / 2^shift).
   function automatic longint ref_scaled(input int x, input int sc, input int sh);
      longint num;
      longint den;
      longint q;
      num = longint'(x) * longint'(sc);
      if (sh == 0) return num;
      den = longint'(1) << sh;
      num = num + den / 2;
      q = num / den;
      if (num < 0 && q * den != num) q = q - 1;
      return q;
   endfunction

   function automatic int clamp8(input longint r);
      if (r > 127) return 127;
      if (r < -128) return -128;
      return int'(r);
   endfunction

   // Monitor / scoreboard: predict at the falling edge, commit at the rising edge.
   initial begin : monitor
      bit     exp_ov;
      bit     do_pop;
      bit     do_acc;
      bit     do_cfg;
      int     v;
      longint r;
      item_t  it;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            m_scale = 1;
            m_shift = 0;
            m_sat = 0;
            last_pop = 0;
            exp_cfg_err = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_x_out", $signed(x_out), 0);
            chk("rst_busy", busy, 0);
            chk("rst_cfg_err", cfg_err, 0);
         end else begin
            exp_ov = (exp_q.size() > 0) && ((cyc - exp_q[0].t) >= 2);
            chk("busy", busy, int'(exp_q.size() != 0));
            chk("in_ready", in_ready, int'(exp_q.size() < DEPTH));
            chk("out_valid", out_valid, int'(exp_ov));
            chk("cfg_err", cfg_err, int'(exp_cfg_err));
            if (exp_ov) chk("x_out", $signed(x_out), exp_q[0].v);
            else        chk("x_out_hold", $signed(x_out), last_pop);
            do_pop = exp_ov && out_ready;
            do_acc = in_valid && (exp_q.size() < DEPTH);
            do_cfg = cfg_load && (exp_q.size() == 0) && !do_acc;
            v = 0;
            r = 0;
            if (do_acc) begin
               r = ref_scaled(int'($signed(in_data)), m_scale, m_shift);
               v = clamp8(r);
            end
            @(posedge clk);
            cyc++;
            if (do_pop) begin
               $display("OUT x_out=%0d cyc=%0d", exp_q[0].v, cyc);
               last_pop = exp_q[0].v;
               got_q.push_back(exp_q[0].v);
               void'(exp_q.pop_front());
            end
            if (do_acc) begin
               it.v = v;
               it.t = cyc;
               exp_q.push_back(it);
               n_acc++;
               if (longint'(v) != r && m_sat < 65535) m_sat++;
            end
            if (do_cfg) begin
               m_scale = int'(cfg_scale);
               m_shift = int'(cfg_shift);
               m_sat = 0;
            end
            exp_cfg_err = cfg_load && !do_cfg;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one value and hold it until it is taken (bounded).
   task automatic send(input int val);
      bit ok;
      int n;
      in_valid = 1'b1;
      in_data  = 24'(val);
      n = 0;
      do begin
         ok = in_ready;
         tick();
         n++;
      end while (!ok && n < 100);
      chk("send_accept", int'(ok), 1);
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk("drain_idle", busy, 0);
`ifdef REQUANT_SAT_CNT_EN
      chk("sat_count", int'(sat_count), m_sat);
`endif
   endtask

   task automatic cfg(input int sc, input int sh);
      cfg_load  = 1'b1;
      cfg_scale = 16'(sc);
      cfg_shift = 5'(sh);
      tick();
      cfg_load  = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      cfg_load = 1'b0;
      reset    = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 1);
      repeat (2) tick();
      reset = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int acc0;
      int c0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Identity: scale 1, shift 0 after reset.
      out_ready = 1'b1;
      got_q.delete();
      send(100);
      send(300);
      send(-300);
      drain();
      chk("id_count", got_q.size(), 3);
      chk("id_0", got_q[0], 100);
      chk("id_1", got_q[1], 127);
      chk("id_2", got_q[2], -128);

      // Rounding half toward +inf.
      cfg(3, 2);
      got_q.delete();
      send(10);
      send(-10);
      send(2);
      drain();
      chk("rnd_count", got_q.size(), 3);
      chk("rnd_0", got_q[0], 8);
      chk("rnd_1", got_q[1], -7);
      chk("rnd_2", got_q[2], 2);

      // Backpressure: 6 offered with out_ready low, only 4 fit.
      out_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 24'(i * 7 - 20);
         tick();
      end
      in_valid = 1'b0;
      chk("bp_accepted", n_acc - acc0, 4);
      chk("bp_in_ready_low", in_ready, 0);
      repeat (3) tick();
      out_ready = 1'b1;
      drain();
      chk("bp_in_ready_back", in_ready, 1);

      // Streaming: 32 back-to-back values, one per cycle.
      cfg(3, 4);
      c0 = cyc;
      for (int i = 0; i < 32; i++) begin
         send(int'($urandom_range(0, 4000)) - 2000);
      end
      chk("stream_cycles", cyc - c0, 32);
      drain();

      // Config guard: load while busy is rejected, old scale kept.
      cfg(2, 0);
      send(10);
      send(20);
      in_valid = 1'b0;
      cfg(7, 0);
      drain();
      cfg(7, 0);
      got_q.delete();
      send(10);
      drain();
      chk("guard_new_scale", got_q[0], 70);
      // Load in the same cycle as an input accept is also rejected.
      in_valid  = 1'b1;
      in_data   = 24'(5);
      cfg_load  = 1'b1;
      cfg_scale = 16'd9;
      tick();
      cfg_load  = 1'b0;
      drain();

      // Randomized traffic with random backpressure and config attempts.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = ($urandom_range(0, 1) != 0) ? 24'($urandom)
                                                 : 24'(int'($urandom_range(0, 400)) - 200);
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_load  = ($urandom_range(0, 15) == 0);
         cfg_scale = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
         cfg_shift = 5'($urandom);
         tick();
      end
      cfg_load  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset with values in flight; nothing stale may appear afterwards.
      send(11);
      send(22);
      send(33);
      do_reset();
      repeat (4) tick();
      chk("post_rst_out_valid", out_valid, 0);
      send(300);
      send(-300);
      send(5);
      drain();
`ifdef REQUANT_SAT_CNT_EN
      chk("sat_after_reset", int'(sat_count), 2);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
